clk_gate_ctrl: RTL and testbench



---
 rtl/clk_gate_pkg.sv | 6 +
 rtl/clk_gate_dcnt.sv | 19 +
 rtl/clk_gate_ctrl.sv | 89 ++++++++
 tb/tb_clk_gate_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/clk_gate_pkg.sv
// clk_gate_pkg: shared state encoding and default sizes for the clock-gate controller
package clk_gate_pkg;
  typedef enum logic [1:0] {RUN, IDLE_CNT, GATED, WAKE} clk_gate_state_t;
  localparam int WAKE_CYCLES_DEF = 4;
  localparam int IDLE_W_DEF = 16;
endpackage

// File: rtl/clk_gate_dcnt.sv
// clk_gate_dcnt: loadable down-counter with zero flag, holds at zero
module clk_gate_dcnt #(
  parameter int W = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (reset) cnt <= RST_VAL;
    else if (load) cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: ICG enable controller with idle auto-gating and wake settle; stats under CLKGATE_STATS_EN
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int IDLE_W = IDLE_W_DEF,
  parameter int WAKE_CYCLES = WAKE_CYCLES_DEF,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              busy,
  input  logic              wake_req,
  input  logic              force_on,
  input  logic [IDLE_W-1:0] idle_cycles,
  output logic              gate_en,
  output logic              clk_ready,
  output logic              gated,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_gate_events,
  output logic [STAT_W-1:0] stat_gated_cycles
);
  clk_gate_state_t state, nxt;
  logic act, idle_load, idle_dec, idle_zero, wake_load, wake_dec, wake_zero;
  assign act = busy | wake_req | force_on;
  // The idle cycle spent in RUN is the first one counted, so the counter holds N-2
  clk_gate_dcnt #(.W(IDLE_W)) u_idle (
    .clk(clk), .reset(reset), .load(idle_load), .load_val(idle_cycles - IDLE_W'(2)),
    .dec(idle_dec), .zero(idle_zero)
  );
  clk_gate_dcnt #(.W(8), .RST_VAL(8'(WAKE_CYCLES - 1))) u_wake (
    .clk(clk), .reset(reset), .load(wake_load), .load_val(8'(WAKE_CYCLES - 1)),
    .dec(wake_dec), .zero(wake_zero)
  );
  always_comb begin
    nxt = state;
    idle_load = 1'b0;
    idle_dec = 1'b0;
    wake_load = 1'b0;
    wake_dec = 1'b0;
    case (state)
      RUN: if (!act && idle_cycles != '0) begin
        nxt = idle_cycles == IDLE_W'(1) ? GATED : IDLE_CNT;
        idle_load = 1'b1;
      end
      IDLE_CNT: begin
        nxt = act ? RUN : idle_zero ? GATED : IDLE_CNT;
        idle_dec = !act && !idle_zero;
      end
      GATED: if (wake_req | force_on) begin
        nxt = WAKE;
        wake_load = 1'b1;
      end
      default: begin
        nxt = wake_zero ? RUN : WAKE;
        wake_dec = !wake_zero;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= WAKE;
      gate_en <= 1'b1;
      clk_ready <= 1'b0;
      gated <= 1'b0;
    end else begin
      state <= nxt;
      gate_en <= nxt != GATED;
      clk_ready <= nxt == RUN || nxt == IDLE_CNT;
      gated <= nxt == GATED;
    end
`ifdef CLKGATE_STATS_EN
  logic [STAT_W-1:0] ev, cyc;
  always_ff @(posedge clk)
    if (reset || stat_clr) begin
      ev <= '0;
      cyc <= '0;
    end else begin
      if (nxt == GATED && state != GATED && ev != '1) ev <= ev + 1'b1;
      if (!gate_en) cyc <= cyc + 1'b1;
    end
  assign stat_gate_events = ev;
  assign stat_gated_cycles = cyc;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_gate_events = '0;
  assign stat_gated_cycles = '0;
`endif
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl: directed and random checks of clk_gate_ctrl against a cycle-count reference model
module tb_clk_gate_ctrl;
  localparam int WC = 4;
`ifdef CLKGATE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, busy = 1'b0, wake_req = 1'b0, force_on = 1'b0, stat_clr = 1'b0;
  logic [15:0] idle_cycles = 16'd0;
  logic gate_en, clk_ready, gated;
  logic [31:0] stat_gate_events, stat_gated_cycles;
  int n_chk = 0, n_fail = 0;
  bit m_gated;
  int m_wait, m_streak, m_thr;
  longint m_ev, m_cyc;

  clk_gate_ctrl #(.IDLE_W(16), .WAKE_CYCLES(WC), .STAT_W(32)) dut (
    .clk(clk), .reset(reset), .busy(busy), .wake_req(wake_req), .force_on(force_on),
    .idle_cycles(idle_cycles), .gate_en(gate_en), .clk_ready(clk_ready), .gated(gated),
    .stat_clr(stat_clr), .stat_gate_events(stat_gate_events), .stat_gated_cycles(stat_gated_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: the domain is either gated or on; when on it waits m_wait edges to settle,
  // then counts a streak of idle cycles against a threshold latched at the streak's start.
  task automatic model();
    bit was_gated, new_gate;
    was_gated = m_gated;
    new_gate = 1'b0;
    if (reset) begin
      m_gated = 1'b0; m_wait = WC; m_streak = 0; m_ev = 0; m_cyc = 0;
    end else begin
      if (m_gated) begin
        if (wake_req || force_on) begin m_gated = 1'b0; m_wait = WC; end
      end else if (m_wait > 0) m_wait--;
      else if (busy || wake_req || force_on) m_streak = 0;
      else begin
        if (m_streak == 0) m_thr = idle_cycles;
        if (m_thr != 0) begin
          m_streak++;
          if (m_streak == m_thr) begin m_gated = 1'b1; m_streak = 0; new_gate = 1'b1; end
        end
      end
      if (stat_clr) begin m_ev = 0; m_cyc = 0; end
      else begin
        if (new_gate && m_ev < 64'hFFFF_FFFF) m_ev++;
        if (was_gated) m_cyc = (m_cyc + 1) % 64'h1_0000_0000;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    chk("gate_en", gate_en, 32'(!m_gated));
    chk("clk_ready", clk_ready, 32'(!m_gated && m_wait == 0));
    chk("gated", gated, 32'(m_gated));
    chk("stat_gate_events", stat_gate_events, STATS ? 32'(m_ev) : 32'd0);
    chk("stat_gated_cycles", stat_gated_cycles, STATS ? 32'(m_cyc) : 32'd0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #2;
    steps(2);
    chk("rst_gate_en", gate_en, 1);
    chk("rst_clk_ready", clk_ready, 0);
    reset = 1'b0;
    busy = 1'b1;
    steps(3);
    chk("rel_not_ready_3", clk_ready, 0);
    step();
    chk("rel_ready_4", clk_ready, 1);
    busy = 1'b0;
    idle_cycles = 16'd10;
    for (int k = 0; k < 3; k++) begin
      steps(9);
      chk("pre_gate_on", gate_en, 1);
      step();
      chk("auto_gate_en", gate_en, 0);
      chk("auto_gated", gated, 1);
      busy = 1'b1;
      steps(19);
      busy = 1'b0;
      wake_req = 1'b1;
      step();
      wake_req = 1'b0;
      chk("wake_gate_en", gate_en, 1);
      chk("wake_not_ready", clk_ready, 0);
      steps(3);
      chk("wake_not_ready_3", clk_ready, 0);
      step();
      chk("wake_ready_4", clk_ready, 1);
    end
    busy = 1'b1;
    step();
    chk("stats_events", stat_gate_events, STATS ? 32'd3 : 32'd0);
    chk("stats_cycles", stat_gated_cycles, STATS ? 32'd60 : 32'd0);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("stats_clr_events", stat_gate_events, 0);
    chk("stats_clr_cycles", stat_gated_cycles, 0);
    busy = 1'b0;
    steps(8);
    busy = 1'b1;
    step();
    busy = 1'b0;
    steps(9);
    chk("abort_still_on", gate_en, 1);
    step();
    chk("abort_fresh_gate", gate_en, 0);
    force_on = 1'b1;
    steps(WC + 1);
    idle_cycles = 16'd3;
    steps(50);
    chk("force_on_never_gates", gate_en, 1);
    force_on = 1'b0;
    idle_cycles = 16'd0;
    steps(100);
    chk("idle0_never_gates", gate_en, 1);
    idle_cycles = 16'd1;
    step();
    chk("idle1_gates_first", gate_en, 0);
    steps(5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("reset_in_gated_gate_en", gate_en, 1);
    chk("reset_in_gated_ready", clk_ready, 0);
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(299) == 0;
      busy = $urandom_range(99) < 30;
      wake_req = $urandom_range(99) < 5;
      force_on = $urandom_range(99) < 3;
      stat_clr = $urandom_range(99) < 2;
      if ($urandom_range(19) == 0) idle_cycles = 16'($urandom_range(8));
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
